// File: rtl/relu_maxpool2d_if.sv
// Memory-side buses of the ReLU/max-pool stage: conv buffer read port and pool buffer write port.
// The pooling engine is the master; the BRAMs (or a bench model) sit on the slave side.
interface relu_maxpool2d_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CONV_AW    = 13,
  parameter int unsigned POOL_AW    = 11
);
  logic        [CONV_AW-1:0]    conv_addr;
  logic                         conv_en;
  logic signed [DATA_WIDTH-1:0] conv_q;
  logic        [POOL_AW-1:0]    pool_addr;
  logic                         pool_en;
  logic                         pool_we;
  logic signed [DATA_WIDTH-1:0] pool_d;

  modport master (
    output conv_addr, conv_en,
    input  conv_q,
    output pool_addr, pool_en, pool_we, pool_d
  );

  modport slave (
    input  conv_addr, conv_en,
    output conv_q,
    input  pool_addr, pool_en, pool_we, pool_d
  );
endinterface

// File: rtl/relu_maxpool2d.sv
// Fused ReLU + POOLxPOOL max-pooling: reads every window from the conv buffer, keeps a
// zero-seeded running maximum and writes one pooled word per window to the pool buffer.
module relu_maxpool2d #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned IMG_SIZE   = 28,
  parameter int unsigned POOL       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  relu_maxpool2d_if.master bus,
  output logic             busy,
  output logic             done
);
  localparam int unsigned OUT_SIZE   = IMG_SIZE / POOL;
  localparam int unsigned CONV_WORDS = CHANNELS * IMG_SIZE * IMG_SIZE;
  localparam int unsigned POOL_WORDS = CHANNELS * OUT_SIZE * OUT_SIZE;
  localparam int unsigned CONV_AW    = (CONV_WORDS > 1) ? $clog2(CONV_WORDS) : 1;
  localparam int unsigned POOL_AW    = (POOL_WORDS > 1) ? $clog2(POOL_WORDS) : 1;
  localparam int unsigned CH_W       = $clog2(CHANNELS + 1);
  localparam int unsigned OW         = $clog2(OUT_SIZE + 1);
  localparam int unsigned PW         = $clog2(POOL + 1);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [OW-1:0]   O_LAST  = OW'(OUT_SIZE - 1);
  localparam logic [PW-1:0]   P_LAST  = PW'(POOL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        [CH_W-1:0]       r_ch;
  logic        [OW-1:0]         r_orow;
  logic        [OW-1:0]         r_ocol;
  logic        [PW-1:0]         r_pr;
  logic        [PW-1:0]         r_pc;
  logic                         r_drain;
  logic signed [DATA_WIDTH-1:0] r_wmax;
  logic                         r_rd_vld;

  logic                         r_conv_en;
  logic        [CONV_AW-1:0]    r_conv_addr;
  logic                         r_pool_we;
  logic        [POOL_AW-1:0]    r_pool_addr;
  logic signed [DATA_WIDTH-1:0] r_pool_d;
  logic                         r_done;

  logic                         w_win_last;
  logic                         w_pix_last;
  logic                         w_busy;
  logic                         w_conv_en;
  logic                         w_pool_we;
  logic                         w_done;
  logic        [CONV_AW-1:0]    w_conv_addr;
  logic        [POOL_AW-1:0]    w_pool_addr;

  assign w_win_last = (r_pr == P_LAST) && (r_pc == P_LAST);
  assign w_pix_last = (r_ch == CH_LAST) && (r_orow == O_LAST) && (r_ocol == O_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_READ;
      S_READ:   if (w_win_last) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_drain) w_state_nxt = S_WRITE;
      S_WRITE:  w_state_nxt = w_pix_last ? S_FINISH : S_READ;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_conv_en   = (r_state == S_READ);
    w_pool_we   = (r_state == S_WRITE);
    w_done      = (r_state == S_FINISH);
    w_conv_addr = CONV_AW'((32'(r_ch) * IMG_SIZE + 32'(r_orow) * POOL + 32'(r_pr)) * IMG_SIZE
                           + 32'(r_ocol) * POOL + 32'(r_pc));
    w_pool_addr = POOL_AW'((32'(r_ch) * OUT_SIZE + 32'(r_orow)) * OUT_SIZE + 32'(r_ocol));
  end

  // conv_q lags conv_en by one cycle, so r_rd_vld is the qualifier for the running max.
  // The max is re-seeded with zero before every window, which is what makes this a ReLU.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch        <= '0;
      r_orow      <= '0;
      r_ocol      <= '0;
      r_pr        <= '0;
      r_pc        <= '0;
      r_drain     <= 1'b0;
      r_wmax      <= '0;
      r_rd_vld    <= 1'b0;
      r_conv_en   <= 1'b0;
      r_conv_addr <= '0;
      r_pool_we   <= 1'b0;
      r_pool_addr <= '0;
      r_pool_d    <= '0;
      r_done      <= 1'b0;
    end else begin
      r_conv_en <= w_conv_en;
      r_pool_we <= w_pool_we;
      r_done    <= w_done;
      r_rd_vld  <= r_conv_en;
      if (w_conv_en) r_conv_addr <= w_conv_addr;
      if (w_pool_we) begin
        r_pool_addr <= w_pool_addr;
        r_pool_d    <= r_wmax;
      end
      if (r_rd_vld && (bus.conv_q > r_wmax)) r_wmax <= bus.conv_q;

      case (r_state)
        S_IDLE: begin
          r_ch    <= '0;
          r_orow  <= '0;
          r_ocol  <= '0;
          r_pr    <= '0;
          r_pc    <= '0;
          r_drain <= 1'b0;
          r_wmax  <= '0;
        end
        S_READ: begin
          r_drain <= 1'b0;
          if (r_pc == P_LAST) begin
            r_pc <= '0;
            r_pr <= (r_pr == P_LAST) ? '0 : r_pr + 1'b1;
          end else begin
            r_pc <= r_pc + 1'b1;
          end
        end
        S_DRAIN: r_drain <= ~r_drain;
        S_WRITE: begin
          r_wmax <= '0;
          if (r_ocol == O_LAST) begin
            r_ocol <= '0;
            if (r_orow == O_LAST) begin
              r_orow <= '0;
              r_ch   <= r_ch + 1'b1;
            end else begin
              r_orow <= r_orow + 1'b1;
            end
          end else begin
            r_ocol <= r_ocol + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.conv_en   = r_conv_en;
  assign bus.conv_addr = r_conv_addr;
  assign bus.pool_en   = r_pool_we;
  assign bus.pool_we   = r_pool_we;
  assign bus.pool_addr = r_pool_addr;
  assign bus.pool_d    = r_pool_d;
  assign busy          = w_busy;
  assign done          = r_done;
endmodule

// File: tb/tb_relu_maxpool2d.sv
// Bench for relu_maxpool2d: a small odd-sized instance (2ch, 5x5) and a default-sized one,
// each fed from a BRAM model and checked against a window-max reference computed here.
module tb_relu_maxpool2d;
  localparam int unsigned DW      = 16;
  localparam int unsigned A_CH    = 2;
  localparam int unsigned A_IMG   = 5;
  localparam int unsigned A_P     = 2;
  localparam int unsigned A_OUT   = A_IMG / A_P;
  localparam int unsigned A_N     = A_CH * A_OUT * A_OUT;
  localparam int unsigned A_WORDS = A_CH * A_IMG * A_IMG;
  localparam int unsigned A_CAW   = $clog2(A_WORDS);
  localparam int unsigned A_PAW   = $clog2(A_N);
  localparam int unsigned D_CH    = 8;
  localparam int unsigned D_IMG   = 28;
  localparam int unsigned D_P     = 2;
  localparam int unsigned D_OUT   = D_IMG / D_P;
  localparam int unsigned D_N     = D_CH * D_OUT * D_OUT;
  localparam int unsigned D_WORDS = D_CH * D_IMG * D_IMG;
  localparam int unsigned D_CAW   = $clog2(D_WORDS);
  localparam int unsigned D_PAW   = $clog2(D_N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic rst_a_n, start_a, busy_a, done_a;
  logic rst_d_n, start_d, busy_d, done_d;

  relu_maxpool2d_if #(.DATA_WIDTH(DW), .CONV_AW(A_CAW), .POOL_AW(A_PAW)) bus_a ();
  relu_maxpool2d_if #(.DATA_WIDTH(DW), .CONV_AW(D_CAW), .POOL_AW(D_PAW)) bus_d ();

  relu_maxpool2d #(.DATA_WIDTH(DW), .CHANNELS(A_CH), .IMG_SIZE(A_IMG), .POOL(A_P)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .start(start_a), .bus(bus_a), .busy(busy_a), .done(done_a));
  relu_maxpool2d #(.DATA_WIDTH(DW), .CHANNELS(D_CH), .IMG_SIZE(D_IMG), .POOL(D_P)) dut_d (
    .clk(clk), .reset_n(rst_d_n), .start(start_d), .bus(bus_d), .busy(busy_d), .done(done_d));

  logic signed [DW-1:0] mem_a [A_WORDS];
  logic signed [DW-1:0] mem_d [D_WORDS];
  always @(posedge clk) if (bus_a.conv_en) bus_a.conv_q <= mem_a[bus_a.conv_addr];
  always @(posedge clk) if (bus_d.conv_en) bus_d.conv_q <= mem_d[bus_d.conv_addr];

  logic [A_PAW-1:0] wa_addr[$];
  logic signed [DW-1:0] wa_data[$];
  logic [D_PAW-1:0] wd_addr[$];
  logic signed [DW-1:0] wd_data[$];
  int unsigned done_cnt_a = 0, viol_a = 0, done_edge_a = 0;
  int unsigned done_cnt_d = 0, viol_d = 0, done_edge_d = 0, busy_cnt_d = 0;
  logic pw_prev_a = 1'b0, pw_prev_d = 1'b0, done_busy_d = 1'b0;

  // Protocol watch: single-cycle writes, en==we, reads only while busy and inside the pooled area.
  always @(negedge clk) begin
    pw_prev_a <= bus_a.pool_we;
    if (bus_a.pool_we) begin
      wa_addr.push_back(bus_a.pool_addr);
      wa_data.push_back(bus_a.pool_d);
    end
    if ((bus_a.pool_we && pw_prev_a) || (bus_a.pool_we !== bus_a.pool_en) ||
        (bus_a.conv_en && (!busy_a || (32'(bus_a.conv_addr) % A_IMG) >= A_OUT * A_P ||
                           ((32'(bus_a.conv_addr) / A_IMG) % A_IMG) >= A_OUT * A_P)))
      viol_a <= viol_a + 1;
    if (done_a) begin
      done_cnt_a  <= done_cnt_a + 1;
      done_edge_a <= edge_n;
    end
  end

  always @(negedge clk) begin
    pw_prev_d <= bus_d.pool_we;
    if (bus_d.pool_we) begin
      wd_addr.push_back(bus_d.pool_addr);
      wd_data.push_back(bus_d.pool_d);
    end
    if ((bus_d.pool_we && pw_prev_d) || (bus_d.pool_we !== bus_d.pool_en) ||
        (bus_d.conv_en && !busy_d))
      viol_d <= viol_d + 1;
    if (busy_d) busy_cnt_d <= busy_cnt_d + 1;
    if (done_d) begin
      done_cnt_d  <= done_cnt_d + 1;
      done_edge_d <= edge_n;
      done_busy_d <= busy_d;
    end
  end

  int exp_a[A_N];
  int exp_d[D_N];
  int unsigned e0_a, e0_d, base_done_a, base_viol_a, base_done_d, base_viol_d, base_busy_d;

  task automatic model_a;
    for (int ch = 0; ch < A_CH; ch++)
      for (int orow = 0; orow < A_OUT; orow++)
        for (int ocol = 0; ocol < A_OUT; ocol++) begin
          int m = 0;
          for (int pr = 0; pr < A_P; pr++)
            for (int pc = 0; pc < A_P; pc++) begin
              int v = mem_a[(ch * A_IMG + orow * A_P + pr) * A_IMG + ocol * A_P + pc];
              if (v > m) m = v;
            end
          exp_a[(ch * A_OUT + orow) * A_OUT + ocol] = m;
        end
  endtask

  task automatic model_d;
    for (int ch = 0; ch < D_CH; ch++)
      for (int orow = 0; orow < D_OUT; orow++)
        for (int ocol = 0; ocol < D_OUT; ocol++) begin
          int m = 0;
          for (int pr = 0; pr < D_P; pr++)
            for (int pc = 0; pc < D_P; pc++) begin
              int v = mem_d[(ch * D_IMG + orow * D_P + pr) * D_IMG + ocol * D_P + pc];
              if (v > m) m = v;
            end
          exp_d[(ch * D_OUT + orow) * D_OUT + ocol] = m;
        end
  endtask

  task automatic kick_a;
    @(negedge clk);
    wa_addr.delete(); wa_data.delete();
    base_done_a = done_cnt_a; base_viol_a = viol_a;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; e0_a = edge_n;
  endtask

  task automatic kick_d;
    @(negedge clk);
    wd_addr.delete(); wd_data.delete();
    base_done_d = done_cnt_d; base_viol_d = viol_d; base_busy_d = busy_cnt_d;
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0; e0_d = edge_n;
  endtask

  task automatic test_reset;
    rst_a_n = 1'b0; rst_d_n = 1'b0; start_a = 1'b0; start_d = 1'b0;
    repeat (3) @(negedge clk);
    start_a = 1'b1; start_d = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_d = 1'b0;
    if (bus_a.conv_en !== 1'b0)  begin errors++; $display("FAIL rst_conv_en: got %b want 0", bus_a.conv_en); end checks++;
    if (bus_a.conv_addr !== '0)  begin errors++; $display("FAIL rst_conv_addr: got %0d want 0", bus_a.conv_addr); end checks++;
    if (bus_a.pool_en !== 1'b0)  begin errors++; $display("FAIL rst_pool_en: got %b want 0", bus_a.pool_en); end checks++;
    if (bus_a.pool_we !== 1'b0)  begin errors++; $display("FAIL rst_pool_we: got %b want 0", bus_a.pool_we); end checks++;
    if (bus_a.pool_addr !== '0)  begin errors++; $display("FAIL rst_pool_addr: got %0d want 0", bus_a.pool_addr); end checks++;
    if (bus_a.pool_d !== '0)     begin errors++; $display("FAIL rst_pool_d: got %0d want 0", bus_a.pool_d); end checks++;
    if (busy_a !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b want 0", busy_a); end checks++;
    if (done_a !== 1'b0)         begin errors++; $display("FAIL rst_done: got %b want 0", done_a); end checks++;
    if ({bus_d.conv_en, bus_d.pool_we, busy_d, done_d} !== 4'b0)
      begin errors++; $display("FAIL rst_d_ctrl: got %b want 0000", {bus_d.conv_en, bus_d.pool_we, busy_d, done_d}); end
    checks++;
    rst_a_n = 1'b1; rst_d_n = 1'b1;
    repeat (2) @(negedge clk);
    if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_start_ignored_a: busy got %b want 0", busy_a); end checks++;
    if (busy_d !== 1'b0) begin errors++; $display("FAIL rst_start_ignored_d: busy got %b want 0", busy_d); end checks++;
  endtask

  // Scenarios: 0 ramp, 1 all-negative, 2..5 max at each window position, 6..9 random.
  // Trailing row/column holds 32767 so any stray read of it shows up in the result.
  task automatic test_small;
    for (int scen = 0; scen < 10; scen++) begin
      int dcyc;
      for (int idx = 0; idx < A_WORDS; idx++) begin
        int ch = idx / (A_IMG * A_IMG);
        int r  = (idx % (A_IMG * A_IMG)) / A_IMG;
        int c  = idx % A_IMG;
        int v;
        if (r >= A_OUT * A_P || c >= A_OUT * A_P) v = 32767;
        else if (scen == 0) v = (ch == 0) ? r * 4 + c : -7;
        else if (scen == 1) v = ($urandom_range(1) != 0) ? -32768 : -3;
        else if (scen < 6)  v = (((r % 2) * 2 + (c % 2)) == scen - 2) ? 100 : -5;
        else                v = int'($urandom_range(65535)) - 32768;
        mem_a[idx] = DW'(v);
      end
      model_a();
      if (scen == 0) begin exp_a[0] = 5; exp_a[1] = 7; exp_a[2] = 13; exp_a[3] = 15; end
      kick_a();
      for (int i = 0; i < 200 && (done_cnt_a - base_done_a) == 0; i++) begin
        @(negedge clk);
        start_a = (scen == 6) && (i == 10 || i == 55);
      end
      start_a = 1'b0;
      repeat (5) @(negedge clk);
      dcyc = int'(done_edge_a - e0_a) + 1;
      if (done_cnt_a - base_done_a != 1) begin errors++; $display("FAIL s%0d_done_count: got %0d want 1", scen, done_cnt_a - base_done_a); end checks++;
      if (dcyc != 7 * A_N + 2) begin errors++; $display("FAIL s%0d_done_cycle: got %0d want %0d", scen, dcyc, 7 * A_N + 2); end checks++;
      if (busy_a !== 1'b0) begin errors++; $display("FAIL s%0d_busy_after: got %b want 0", scen, busy_a); end checks++;
      if (viol_a != base_viol_a) begin errors++; $display("FAIL s%0d_protocol: got %0d violations want 0", scen, viol_a - base_viol_a); end checks++;
      if (wa_addr.size() != A_N) begin errors++; $display("FAIL s%0d_write_count: got %0d want %0d", scen, wa_addr.size(), A_N); end checks++;
      for (int i = 0; i < A_N && i < wa_addr.size(); i++) begin
        if (int'(wa_addr[i]) != i) begin errors++; $display("FAIL s%0d_addr[%0d]: got %0d want %0d", scen, i, wa_addr[i], i); end checks++;
        if (int'(wa_data[i]) != exp_a[i]) begin errors++; $display("FAIL s%0d_data[%0d]: got %0d want %0d", scen, i, wa_data[i], exp_a[i]); end checks++;
      end
    end
  endtask

  // Run 0: random data with stray start pulses (one lands in FINISH).
  // Run 1: abort by reset at cycle 500, then restart and expect the full result.
  task automatic test_default;
    for (int run = 0; run < 2; run++) begin
      int dcyc;
      for (int idx = 0; idx < D_WORDS; idx++) mem_d[idx] = DW'($urandom);
      model_d();
      if (run == 1) begin
        kick_d();
        while (edge_n - e0_d + 1 < 500) @(negedge clk);
        rst_d_n = 1'b0;
        #1;
        if (wd_addr.size() != 71) begin errors++; $display("FAIL abort_writes_before: got %0d want 71", wd_addr.size()); end checks++;
        if ({bus_d.conv_en, bus_d.pool_en, bus_d.pool_we, busy_d, done_d} !== 5'b0)
          begin errors++; $display("FAIL abort_ctrl: got %b want 00000", {bus_d.conv_en, bus_d.pool_en, bus_d.pool_we, busy_d, done_d}); end
        checks++;
        if (bus_d.conv_addr !== '0 || bus_d.pool_addr !== '0 || bus_d.pool_d !== '0)
          begin errors++; $display("FAIL abort_data: got %0d/%0d/%0d want 0/0/0", bus_d.conv_addr, bus_d.pool_addr, bus_d.pool_d); end
        checks++;
        repeat (10) @(negedge clk);
        rst_d_n = 1'b1;
        repeat (10) @(negedge clk);
        if (done_cnt_d != base_done_d) begin errors++; $display("FAIL abort_no_done: got %0d want 0", done_cnt_d - base_done_d); end checks++;
        if (busy_d !== 1'b0) begin errors++; $display("FAIL abort_idle: busy got %b want 0", busy_d); end checks++;
      end
      kick_d();
      for (int i = 0; i < 12000 && (done_cnt_d - base_done_d) == 0; i++) begin
        @(negedge clk);
        start_d = (run == 0) && (i == 100 || i == 3000 || i == 10975);
      end
      start_d = 1'b0;
      repeat (20) @(negedge clk);
      dcyc = int'(done_edge_d - e0_d) + 1;
      if (done_cnt_d - base_done_d != 1) begin errors++; $display("FAIL r%0d_done_count: got %0d want 1", run, done_cnt_d - base_done_d); end checks++;
      if (dcyc != 7 * D_N + 2) begin errors++; $display("FAIL r%0d_done_cycle: got %0d want %0d", run, dcyc, 7 * D_N + 2); end checks++;
      if (done_busy_d !== 1'b0) begin errors++; $display("FAIL r%0d_busy_at_done: got %b want 0", run, done_busy_d); end checks++;
      if (busy_cnt_d - base_busy_d != 7 * D_N + 1) begin errors++; $display("FAIL r%0d_busy_cycles: got %0d want %0d", run, busy_cnt_d - base_busy_d, 7 * D_N + 1); end checks++;
      if (viol_d != base_viol_d) begin errors++; $display("FAIL r%0d_protocol: got %0d violations want 0", run, viol_d - base_viol_d); end checks++;
      if (wd_addr.size() != D_N) begin errors++; $display("FAIL r%0d_write_count: got %0d want %0d", run, wd_addr.size(), D_N); end checks++;
      for (int i = 0; i < D_N && i < wd_addr.size(); i++) begin
        if (int'(wd_addr[i]) != i) begin errors++; $display("FAIL r%0d_addr[%0d]: got %0d want %0d", run, i, wd_addr[i], i); end checks++;
        if (int'(wd_data[i]) != exp_d[i]) begin errors++; $display("FAIL r%0d_data[%0d]: got %0d want %0d", run, i, wd_data[i], exp_d[i]); end checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_default();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
